vc_arbiter: RTL

Two-port arbiter and sequencer in front of `vc_control`. It shares the single victim cache between the L1 data cache (port 0) and the L1 instruction cache (port 1). It accepts eviction writes and lookup reads, grants one request at a time with round-robin priority, and drives the `vc_read`/`vc_write` one-cycle command protocol. It holds address and data stable for the whole transaction, collects the hit or completion indication, and returns a one-cycle response to the granted port.

---
 rtl/vc_arb_pkg.sv | 25 ++
 rtl/vc_arb_rr.sv | 32 +++
 rtl/vc_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vc_arb_pkg.sv
// -----------------------------------------------------------------------------
// vc_arb_pkg
// Shared types for the victim-cache arbiter: the sequencer state encoding, the
// request-type encoding and the (fixed) requester count.
// No ports; imported by vc_arb_rr and vc_arbiter.
// -----------------------------------------------------------------------------
package vc_arb_pkg;

    // Requester count. The round-robin picker is a 2-way design.
    localparam int NUM_PORTS = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        WAIT_WR = 3'd3,
        RESP    = 3'd4
    } state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_type_e;

endpackage

// File: rtl/vc_arb_rr.sv
// -----------------------------------------------------------------------------
// vc_arb_rr
// Two-way round-robin picker. Purely combinational; the last-grant register
// lives in the parent so the pick is only committed when a grant happens.
//
// Ports:
//   req       in  NUM_PORTS  per-port request (any request type)
//   last_gnt  in  1          index of the port granted most recently
//   valid     out 1          at least one request present
//   gnt       out 1          index of the winning port
// -----------------------------------------------------------------------------
module vc_arb_rr
    import vc_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last_gnt,
    output logic                 valid,
    output logic                 gnt
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        if (req[0] && req[1]) begin
            // Contention: the port not served last time wins.
            gnt = ~last_gnt;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
// Two-port arbiter/sequencer in front of vc_control. Port 0 is the L1 data
// cache, port 1 the L1 instruction cache. One request is granted at a time
// (round-robin), its address/line/dirty flag are latched and held for the
// whole transaction, a single-cycle vc_read or vc_write strobe is issued, the
// hit/completion indication is collected and a one-cycle resp pulse is
// returned to the granted port.
//
// Build option:
//   VC_ARB_TIMEOUT_EN  when defined, a write that sees no rdata_exists for
//                      TO_CYCLES cycles completes with resp_err=1; when
//                      undefined, writes wait indefinitely and resp_err is 0.
//
// Ports:
//   clk                 in  1                 rising-edge clock
//   rst                 in  1                 asynchronous reset, active low
//   req_read            in  NUM_PORTS         lookup request (level)
//   req_write           in  NUM_PORTS         eviction request (level)
//   req_addr            in  NUM_PORTS*ADDR_W  per-port line address
//   req_wdata           in  NUM_PORTS*S_LINE  per-port eviction line
//   req_dirty           in  NUM_PORTS         per-port eviction dirty flag
//   resp                out NUM_PORTS         one-cycle completion pulse
//   resp_hit            out 1                 read hit (0 for writes)
//   resp_err            out 1                 write timed out
//   resp_rdata          out S_LINE            read line data
//   vc_read, vc_write   out 1                 command strobes to vc_control
//   mem_address         out ADDR_W            latched address
//   mem_wdata           out S_LINE            latched eviction line
//   is_mem_wdata_dirty  out 1                 latched dirty flag
//   rdata_exists        in  1                 hit/completion from vc_control
//   vc_vcmem_rdata256   in  S_LINE            victim cache data output
// -----------------------------------------------------------------------------
module vc_arbiter
    import vc_arb_pkg::*;
#(
    parameter int S_LINE    = 256,
    parameter int ADDR_W    = 32,
    parameter int TO_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_read,
    input  logic [NUM_PORTS-1:0]              req_write,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][S_LINE-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0]              req_dirty,
    output logic [NUM_PORTS-1:0]              resp,
    output logic                              resp_hit,
    output logic                              resp_err,
    output logic [S_LINE-1:0]                 resp_rdata,
    output logic                              vc_read,
    output logic                              vc_write,
    output logic [ADDR_W-1:0]                 mem_address,
    output logic [S_LINE-1:0]                 mem_wdata,
    output logic                              is_mem_wdata_dirty,
    input  logic                              rdata_exists,
    input  logic [S_LINE-1:0]                 vc_vcmem_rdata256
);

    state_e    state_q;
    state_e    state_d;
    req_type_e type_q;
    logic      gnt_q;
    logic      last_gnt_q;
    logic      wr_done_q;
    logic      wr_timeout;
    logic      rr_valid;
    logic      rr_gnt;

    vc_arb_rr u_rr (
        .req      (req_read | req_write),
        .last_gnt (last_gnt_q),
        .valid    (rr_valid),
        .gnt      (rr_gnt)
    );

`ifdef VC_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign wr_timeout = (to_cnt_q == TO_W'(TO_CYCLES));

    // Counts cycles spent in WAIT_WR; cleared while issuing so every write
    // starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            to_cnt_q <= '0;
        end else if (state_q == WAIT_WR && !wr_timeout) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic to_cycles_unused;

    assign to_cycles_unused = ^TO_CYCLES;
    assign wr_timeout       = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rr_valid) state_d = ISSUE;
            ISSUE:   state_d = (type_q == REQ_WR) ? WAIT_WR : WAIT_RD;
            WAIT_RD: state_d = RESP;
            // Completion is taken from the registered rdata_exists, which puts
            // resp two cycles after the first rdata_exists seen here.
            WAIT_WR: if (wr_done_q || wr_timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command strobes and response pulse are decoded from the state register.
    always_comb begin
        vc_read  = (state_q == ISSUE) && (type_q == REQ_RD);
        vc_write = (state_q == ISSUE) && (type_q == REQ_WR);
        resp     = '0;
        if (state_q == RESP) begin
            resp[gnt_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            type_q             <= REQ_RD;
            gnt_q              <= 1'b0;
            last_gnt_q         <= 1'b1;
            wr_done_q          <= 1'b0;
            mem_address        <= '0;
            mem_wdata          <= '0;
            is_mem_wdata_dirty <= 1'b0;
            resp_hit           <= 1'b0;
            resp_err           <= 1'b0;
            resp_rdata         <= '0;
        end else begin
            state_q   <= state_d;
            wr_done_q <= 1'b0;
            case (state_q)
                // Grant: latch the winner. A port with both requests up is
                // given the write first; its read is picked up later.
                IDLE: begin
                    if (rr_valid) begin
                        gnt_q              <= rr_gnt;
                        last_gnt_q         <= rr_gnt;
                        type_q             <= req_write[rr_gnt] ? REQ_WR : REQ_RD;
                        mem_address        <= req_addr[rr_gnt];
                        mem_wdata          <= req_wdata[rr_gnt];
                        is_mem_wdata_dirty <= req_dirty[rr_gnt];
                    end
                end
                WAIT_RD: begin
                    resp_hit   <= rdata_exists;
                    resp_rdata <= vc_vcmem_rdata256;
                    resp_err   <= 1'b0;
                end
                WAIT_WR: begin
                    wr_done_q <= rdata_exists;
                    if (state_d == RESP) begin
                        resp_hit <= 1'b0;
                        resp_err <= !wr_done_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
